// File: rtl/odd_parity_pkg.sv
// Shared definitions for the odd-parity serial transmitter.
// ODD_PARITY_STOP_BIT_EN adds a trailing STOP state to the frame.
package odd_parity_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam logic        STOP_BIT       = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
`ifdef ODD_PARITY_STOP_BIT_EN
        ,
        STOP   = 2'd3
`endif
    } state_e;

endpackage

// File: rtl/odd_parity_acc.sv
// Single-flop parity accumulator; par_odd is the bit that makes the total ones count odd.
module odd_parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic par_odd
);

    logic acc_q;
    logic acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = 1'b0;
        end else if (en && bit_in) begin
            acc_d = ~acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign par_odd = ~acc_q;

endmodule

// File: rtl/odd_parity_tx_ctrl.sv
// Parallel-to-serial transmitter: LSB-first payload, odd-parity beat, optional stop beat.
// Define ODD_PARITY_STOP_BIT_EN to append a stop beat (tx_bit=1) after parity.
module odd_parity_tx_ctrl
    import odd_parity_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned        CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(DATA_W - 1);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               acc_clr, acc_en, par_odd;

    odd_parity_acc u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .en     (acc_en),
        .bit_in (shift_q[0]),
        .par_odd(par_odd)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tx_ready) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    acc_en  = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (tx_ready) begin
`ifdef ODD_PARITY_STOP_BIT_EN
                    state_d = STOP;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef ODD_PARITY_STOP_BIT_EN
            STOP: begin
                if (tx_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        tx_bit  = 1'b0;
        tx_last = 1'b0;
        case (state_q)
            DATA:   tx_bit = shift_q[0];
            PARITY: begin
                tx_bit = par_odd;
`ifndef ODD_PARITY_STOP_BIT_EN
                tx_last = 1'b1;
`endif
            end
`ifdef ODD_PARITY_STOP_BIT_EN
            STOP: begin
                tx_bit  = STOP_BIT;
                tx_last = 1'b1;
            end
`endif
            default: begin
                tx_bit  = 1'b0;
                tx_last = 1'b0;
            end
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign tx_valid   = (state_q != IDLE);
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;

endmodule
